// File: rtl/bcd_scan_display_if.sv
// Bundle between the BCD counter chain and the scanned 7-segment display driver.
// master: counter side (drives en/digits_in); slave: display driver.
interface bcd_scan_display_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;

  modport master (
    output en, digits_in,
    input  seg, an, digit_idx, frame_done
  );

  modport slave (
    input  en, digits_in,
    output seg, an, digit_idx, frame_done
  );
endinterface

// File: rtl/bcd_scan_display.sv
// Time-multiplexed BCD 7-segment scanner with refresh prescaler, one-cycle
// anti-ghosting blank between slots and a per-frame snapshot of the digits.
// Optional macro LEADING_ZERO_BLANK_EN: suppress leading-zero digits (digit 0
// is always shown); slot timing is unaffected.
module bcd_scan_display #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                clock,
  input  logic                reset,
  bcd_scan_display_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned DIG_W = 4 * NUM_DIGITS;

  localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [PRE_W-1:0]      r_presc;
  logic [DIG_W-1:0]      r_snap;
  logic                  r_frame_done;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  logic [DIG_W-1:0]      w_src;
  logic [3:0]            w_digit;
  logic                  w_show;
  logic [6:0]            w_seg_drive;
  logic [NUM_DIGITS-1:0] w_an_onehot;
  logic [NUM_DIGITS-1:0] w_an_drive;
  logic [IDX_W-1:0]      w_idx_next;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Leaving BLANK for digit 0 the snapshot is loaded on the same edge, so the
  // first DRIVE cycle decodes straight from digits_in.
  assign w_src = (r_state == BLANK && r_idx == '0) ? bus.digits_in : r_snap;
  assign w_digit = 4'(w_src >> {r_idx, 2'b00});

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIG_W-1:0] w_upper;
  // Digit k is suppressed when it and every more significant digit are zero.
  assign w_upper = w_src >> {r_idx, 2'b00};
  assign w_show  = (r_idx == '0) || (w_upper != '0);
`else
  assign w_show = 1'b1;
`endif

  assign w_seg_drive = (SEG_ACTIVE_LOW != 0) ? ~decode(w_digit) : decode(w_digit);
  assign w_an_onehot = NUM_DIGITS'(1) << r_idx;
  assign w_an_drive  = (AN_ACTIVE_LOW != 0) ? ~w_an_onehot : w_an_onehot;
  assign w_idx_next  = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

  // Scan FSM; outputs are loaded with the values belonging to the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_presc      <= '0;
      r_snap       <= '0;
      r_frame_done <= 1'b0;
      r_seg        <= SEG_OFF;
      r_an         <= AN_OFF;
    end else begin
      r_frame_done <= 1'b0;
      r_seg        <= SEG_OFF;
      r_an         <= AN_OFF;
      if (!bus.en) begin
        r_state <= IDLE;
        r_idx   <= '0;
        r_presc <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state      <= BLANK;
            r_idx        <= '0;
            r_presc      <= '0;
            r_frame_done <= 1'b1;
          end
          BLANK: begin
            r_state <= DRIVE;
            r_presc <= '0;
            if (r_idx == '0) begin
              r_snap <= bus.digits_in;
            end
            if (w_show) begin
              r_seg <= w_seg_drive;
              r_an  <= w_an_drive;
            end
          end
          DRIVE: begin
            if (r_presc == PRE_LAST) begin
              r_state      <= BLANK;
              r_presc      <= '0;
              r_idx        <= w_idx_next;
              r_frame_done <= (w_idx_next == '0);
            end else begin
              r_presc <= r_presc + PRE_W'(1);
              if (w_show) begin
                r_seg <= w_seg_drive;
                r_an  <= w_an_drive;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_presc <= '0;
          end
        endcase
      end
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.digit_idx  = r_idx;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: 4 digits, 4-cycle slots, active-low outputs.
module tb_bcd_scan_display;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  bcd_scan_display_if #(.NUM_DIGITS(4)) bus ();

  bcd_scan_display #(
    .NUM_DIGITS    (4),
    .REFRESH_DIV   (4),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled on the falling edge; inputs change there too.
  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.digits_in = 16'h0000;
    repeat (2) @(negedge clk);
    n_total++; if (bus.an !== 4'hF) $display("FAIL reset_an got %h expected %h", bus.an, 4'hF); else n_pass++;
    n_total++; if (bus.seg !== 7'h7F) $display("FAIL reset_seg got %h expected %h", bus.seg, 7'h7F); else n_pass++;
    n_total++; if (bus.frame_done !== 1'b0) $display("FAIL reset_fd got %b expected 0", bus.frame_done); else n_pass++;
    n_total++; if (bus.digit_idx !== 2'd0) $display("FAIL reset_idx got %0d expected 0", bus.digit_idx); else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (bus.an !== 4'hF || bus.frame_done !== 1'b0) $display("FAIL idle_hold got an=%h fd=%b expected an=f fd=0", bus.an, bus.frame_done); else n_pass++;
  endtask

  // One full frame of 1234 plus the start of the next frame.
  task automatic test_scan_1234();
    logic [6:0] segs [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fd;
    int s;
    int p;
    segs[0] = 7'h19; segs[1] = 7'h30; segs[2] = 7'h24; segs[3] = 7'h79;
    bus.en = 1'b0;
    @(negedge clk);
    bus.digits_in = 16'h1234;
    bus.en = 1'b1;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      s = (c / 5) % 4;
      p = c % 5;
      exp_an  = (p == 0) ? 4'hF : ~(4'b0001 << s);
      exp_seg = (p == 0) ? 7'h7F : segs[s];
      exp_fd  = (p == 0) && (s == 0);
      n_total++; if (bus.an !== exp_an) $display("FAIL scan1234_an c=%0d got %h expected %h", c, bus.an, exp_an); else n_pass++;
      n_total++; if (bus.seg !== exp_seg) $display("FAIL scan1234_seg c=%0d got %h expected %h", c, bus.seg, exp_seg); else n_pass++;
      n_total++; if (bus.frame_done !== exp_fd) $display("FAIL scan1234_fd c=%0d got %b expected %b", c, bus.frame_done, exp_fd); else n_pass++;
      n_total++; if (bus.digit_idx !== 2'(s)) $display("FAIL scan1234_idx c=%0d got %0d expected %0d", c, bus.digit_idx, s); else n_pass++;
    end
  endtask

  // Input changes mid-frame appear only from the next frame.
  task automatic test_snapshot();
    logic [6:0] segs_a [4];
    logic [6:0] segs_b [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int s;
    int p;
    segs_a[0] = 7'h19; segs_a[1] = 7'h30; segs_a[2] = 7'h24; segs_a[3] = 7'h79;
    segs_b[0] = 7'h00; segs_b[1] = 7'h78; segs_b[2] = 7'h02; segs_b[3] = 7'h12;
    bus.en = 1'b0;
    @(negedge clk);
    bus.digits_in = 16'h1234;
    bus.en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      s = (c / 5) % 4;
      p = c % 5;
      exp_an  = (p == 0) ? 4'hF : ~(4'b0001 << s);
      exp_seg = (p == 0) ? 7'h7F : ((c < 20) ? segs_a[s] : segs_b[s]);
      n_total++; if (bus.an !== exp_an) $display("FAIL snap_an c=%0d got %h expected %h", c, bus.an, exp_an); else n_pass++;
      n_total++; if (bus.seg !== exp_seg) $display("FAIL snap_seg c=%0d got %h expected %h", c, bus.seg, exp_seg); else n_pass++;
      if (c == 7) bus.digits_in = 16'h5678;
    end
  endtask

  // Dash for code A, zeros (or suppressed leading zeros) above it.
  task automatic test_dash_zero();
    logic [6:0] segs [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int s;
    int p;
    segs[0] = 7'h10; segs[1] = 7'h3F; segs[2] = 7'h40; segs[3] = 7'h40;
    bus.en = 1'b0;
    @(negedge clk);
    bus.digits_in = 16'h00A9;
    bus.en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      s = c / 5;
      p = c % 5;
      exp_an  = (p == 0) ? 4'hF : ~(4'b0001 << s);
      exp_seg = (p == 0) ? 7'h7F : segs[s];
`ifdef LEADING_ZERO_BLANK_EN
      if (s >= 2) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
      end
`endif
      n_total++; if (bus.an !== exp_an) $display("FAIL dash_an c=%0d got %h expected %h", c, bus.an, exp_an); else n_pass++;
      n_total++; if (bus.seg !== exp_seg) $display("FAIL dash_seg c=%0d got %h expected %h", c, bus.seg, exp_seg); else n_pass++;
      n_total++; if (bus.digit_idx !== 2'(s)) $display("FAIL dash_idx c=%0d got %0d expected %0d", c, bus.digit_idx, s); else n_pass++;
    end
  endtask

  // Enable dropped while digit 2 is driven, then restored.
  task automatic test_en_drop();
    bus.en = 1'b0;
    @(negedge clk);
    bus.digits_in = 16'h1234;
    bus.en = 1'b1;
    for (int c = 0; c < 13; c++) @(negedge clk);
    n_total++; if (bus.an !== 4'b1011) $display("FAIL drop_pre_an got %b expected 1011", bus.an); else n_pass++;
    bus.en = 1'b0;
    @(negedge clk);
    n_total++; if (bus.an !== 4'hF) $display("FAIL drop_an got %h expected f", bus.an); else n_pass++;
    n_total++; if (bus.seg !== 7'h7F) $display("FAIL drop_seg got %h expected 7f", bus.seg); else n_pass++;
    n_total++; if (bus.digit_idx !== 2'd0) $display("FAIL drop_idx got %0d expected 0", bus.digit_idx); else n_pass++;
    n_total++; if (bus.frame_done !== 1'b0) $display("FAIL drop_fd got %b expected 0", bus.frame_done); else n_pass++;
    @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    n_total++; if (bus.frame_done !== 1'b1) $display("FAIL reen_fd got %b expected 1", bus.frame_done); else n_pass++;
    n_total++; if (bus.an !== 4'hF) $display("FAIL reen_blank_an got %h expected f", bus.an); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.an !== 4'b1110) $display("FAIL reen_an got %b expected 1110", bus.an); else n_pass++;
    n_total++; if (bus.seg !== 7'h19) $display("FAIL reen_seg got %h expected 19", bus.seg); else n_pass++;
  endtask

  // Reset asserted between clock edges while digit 1 is driven.
  task automatic test_async_reset();
    bus.en = 1'b0;
    @(negedge clk);
    bus.digits_in = 16'h1234;
    bus.en = 1'b1;
    for (int c = 0; c < 8; c++) @(negedge clk);
    n_total++; if (bus.an !== 4'b1101) $display("FAIL arst_pre_an got %b expected 1101", bus.an); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (bus.an !== 4'hF) $display("FAIL arst_an got %h expected f", bus.an); else n_pass++;
    n_total++; if (bus.seg !== 7'h7F) $display("FAIL arst_seg got %h expected 7f", bus.seg); else n_pass++;
    n_total++; if (bus.frame_done !== 1'b0) $display("FAIL arst_fd got %b expected 0", bus.frame_done); else n_pass++;
    n_total++; if (bus.digit_idx !== 2'd0) $display("FAIL arst_idx got %0d expected 0", bus.digit_idx); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus.frame_done !== 1'b1 || bus.an !== 4'hF) $display("FAIL arst_restart_blank got fd=%b an=%h expected fd=1 an=f", bus.frame_done, bus.an); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.an !== 4'b1110) $display("FAIL arst_restart_an got %b expected 1110", bus.an); else n_pass++;
    n_total++; if (bus.seg !== 7'h19) $display("FAIL arst_restart_seg got %h expected 19", bus.seg); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_scan_1234();
    test_snapshot();
    test_dash_zero();
    test_en_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of cascaded decade (BCD) counters.
- Takes NUM_DIGITS packed BCD digits and time-multiplexes them onto one common 7-segment bus with per-digit anode selects.
- Includes a refresh prescaler, an anti-ghosting blank slot and a per-frame snapshot register, so the displayed value never tears mid-frame.
- Sits between the counter chain and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be ≥ 2.
- REFRESH_DIV, 1000: clock cycles each digit is driven per slot; must be ≥ 2.
- SEG_ACTIVE_LOW, 1: 1 inverts seg outputs (common-anode parts).
- AN_ACTIVE_LOW, 1: 1 inverts an outputs.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  scan enable, typically the same enable that drives the counter chain.
- digits_in  input  4*NUM_DIGITS  packed BCD; digit 0 (least significant) is in [3:0].
- seg  output  7  segments {g,f,e,d,c,b,a}; polarity per SEG_ACTIVE_LOW.
- an  output  NUM_DIGITS  one-hot anode select; polarity per AN_ACTIVE_LOW.
- digit_idx  output  clog2(NUM_DIGITS)  index of the current or next digit slot.
- frame_done  output  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Interface: one clock, `clock`. `reset` is asynchronous and active-high.
- Reset values:
  - state = IDLE, digit_idx = 0, prescaler = 0, snapshot = 0, frame_done = 0.
  - seg and an are all inactive (physical level follows the polarity parameters).
- State machine (states IDLE, BLANK, DRIVE):
  - IDLE: an and seg inactive; prescaler and digit_idx held at 0. When en = 1, go to BLANK with digit_idx = 0.
  - BLANK: lasts exactly 1 cycle; an and seg inactive. If digit_idx == 0, snapshot <= digits_in and frame_done = 1 for this cycle. Next state is DRIVE.
  - DRIVE: an asserts only bit digit_idx; seg = decode(snapshot digit[digit_idx]). Prescaler counts 0..REFRESH_DIV-1. At REFRESH_DIV-1, prescaler returns to 0, digit_idx advances (NUM_DIGITS-1 wraps to 0) and the next state is BLANK.
- Output timing: seg, an and frame_done are registered and change on the same edge as the state register. The first DRIVE cycle therefore shows the new digit; no extra latency.
- Slot and frame length:
  - Each slot = 1 BLANK + REFRESH_DIV DRIVE cycles.
  - Frame = NUM_DIGITS*(REFRESH_DIV+1) cycles.
  - frame_done period equals the frame length while en stays high.
- Snapshot: changes to digits_in are visible only from the next frame. Mid-frame changes are ignored.
- Decode (active-high before polarity inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10–15 show "-" (40).
- en falling, in any state: next cycle is IDLE with outputs inactive and digit_idx = 0. A frame in progress is abandoned; the next enable starts a fresh frame at digit 0 with a new snapshot.
- en toggling high again while in IDLE: behaves exactly as the first enable after reset.
- reset mid-scan: everything returns to reset values immediately (asynchronous), regardless of the clock.
- An anode is never asserted in two consecutive slots without an intervening all-off BLANK cycle.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: during DRIVE of digit k > 0, seg and an stay inactive if snapshot digits k..NUM_DIGITS-1 are all zero. Digit 0 is always shown. Slot timing and digit_idx are unchanged.
- Undefined: every digit is always shown, including leading zeros.

Test Plan:
- Sim parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, active-low outputs.
- Reset, then en=1 with digits_in=16'h1234:
  - an cycles 1110→1101→1011→0111.
  - seg (inverted) shows 4,3,2,1, i.e. ~4F… (digit 0 shows ~66).
  - Each slot is 4 DRIVE cycles plus a 1-cycle an=1111 gap.
  - frame_done pulses every 20 cycles.
- digits_in changes 16'h1234→16'h5678 during the digit-1 slot: the rest of that frame still shows 1234; the next frame shows 5678.
- digits_in=16'h00A9: digit 0 shows 9 (~6F); digit 1 shows "-" (~40); digits 2–3 show 0 (~3F), or are blanked with an=1111 under LEADING_ZERO_BLANK_EN.
- en drops during DRIVE of digit 2: the next cycle has an=1111, seg=7F (all off) and digit_idx=0. On re-enable, a BLANK cycle with frame_done=1 comes first, then digit 0.
- reset asserted asynchronously mid-DRIVE, between clock edges: an=1111 and seg=7F immediately, frame_done=0. After release with en=1, scanning restarts from digit 0.
